// File: rtl/vga_scan_compositor.sv
// vga_scan_compositor: VGA raster timing generator and layer compositor.
// Owns the raster position, publishes it on pixel_x/pixel_y for the
// combinational renderers, resolves layer priority and registers the final
// colour together with delay-matched sync and data-enable.
//
// Pixel qualifier: pix_en is a one-clk tick. Every register in this block
// (counters, delay line, outputs) advances only on a clk edge where pix_en
// is high and holds otherwise. The exception is frame_start, which is a
// one-clk pulse that drops on the next clk edge.
module vga_scan_compositor #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_LAT  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_en,
  output logic [9:0]                  pixel_x,
  output logic [9:0]                  pixel_y,
  input  logic [NUM_LAYERS-1:0][11:0] layer_color,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [11:0]                 bg_color,
  output logic [11:0]                 rgb_out,
  output logic                        hsync_n,
  output logic                        vsync_n,
  output logic                        de,
  output logic                        frame_start,
  output logic [7:0]                  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT_W  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BLACK    = 12'h000;

  // Raw timing flags derived from the counters (all active-high here).
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } tim_t;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       wrap;
  tim_t       tim_raw;
  tim_t       tim_d;
  logic [11:0] comp_color;

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;
  assign wrap    = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Raster counters: h wraps into v, v wraps to the top of the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Decode sync windows and the visible area from the current position.
  always_comb begin
    tim_raw.hs  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    tim_raw.vs  = (v_cnt >= VS_START) && (v_cnt < VS_END);
    tim_raw.act = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
  end

  // Delay the timing flags so they line up with late renderer data.
  if (LAYER_LAT == 0) begin : g_no_dly
    assign tim_d = tim_raw;
  end else begin : g_dly
    tim_t dly_q [LAYER_LAT];

    // Pix_en-qualified shift register, cleared to inactive on reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < LAYER_LAT; i++) dly_q[i] <= '0;
      end else if (pix_en) begin
        dly_q[0] <= tim_raw;
        for (int i = 1; i < LAYER_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign tim_d = dly_q[LAYER_LAT-1];
  end

  // Priority select: scanning from the top index down lets index 0 win.
  always_comb begin
    comp_color = bg_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i]) comp_color = layer_color[i];
    end
    if (!tim_d.act) comp_color = BLACK;
  end

  // Output register for the DAC pins: colour, syncs and data enable together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      de      <= 1'b0;
      rgb_out <= BLACK;
    end else if (pix_en) begin
      hsync_n <= ~tim_d.hs;
      vsync_n <= ~tim_d.vs;
      de      <= tim_d.act;
      rgb_out <= comp_color;
    end
  end

  // Frame marker: pulse and count when the raster wraps back to (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en && wrap) begin
        frame_start <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Bench for vga_scan_compositor. Three instances share clk and rst_n:
//   dut_s : shrunken geometry (24x14 total, 16x8 visible), LAYER_LAT=0
//   dut_0 : default 640x480 geometry, LAYER_LAT=0
//   dut_2 : default 640x480 geometry, LAYER_LAT=2
module tb_vga_scan_compositor;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic pe_s  = 1'b0;
  logic pe0   = 1'b0;
  logic pe2   = 1'b0;

  // ---------------- dut_s (small geometry) ----------------
  logic [9:0]       sx, sy;
  logic [3:0][11:0] s_lc;
  logic [3:0]       s_le;
  logic [11:0]      s_rgb;
  logic             s_hs, s_vs, s_de, s_fs;
  logic [7:0]       s_fc;
  int               s_h = 0;
  int               s_v = 0;

  // Model renderers for dut_s, decoded from the bench's own raster model.
  always_comb begin
    s_lc[0] = 12'hF00;
    s_lc[1] = 12'h0F0;
    s_lc[2] = 12'h0FF;
    s_lc[3] = 12'hABC;
    s_le    = 4'b0000;
    if (s_v == 3)              s_le[0] = 1'b1;
    if (s_h < 4)               s_le[1] = 1'b1;
    if (s_h == 5 || s_h == 12) s_le[2] = 1'b1;
    if (s_h >= 12)             s_le[3] = 1'b1;
  end

  vga_scan_compositor #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .NUM_LAYERS(4), .LAYER_LAT(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_s),
    .pixel_x(sx), .pixel_y(sy),
    .layer_color(s_lc), .layer_en(s_le), .bg_color(12'h00F),
    .rgb_out(s_rgb), .hsync_n(s_hs), .vsync_n(s_vs), .de(s_de),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  // ---------------- dut_0 (default geometry, LAT 0) ----------------
  logic [9:0]       zx, zy;
  logic [3:0][11:0] z_lc;
  logic [3:0]       z_le = 4'b0000;
  logic [11:0]      z_rgb;
  logic             z_hs, z_vs, z_de, z_fs;
  logic [7:0]       z_fc;

  assign z_lc[0] = 12'hF00;
  assign z_lc[1] = 12'h123;
  assign z_lc[2] = 12'h0F0;
  assign z_lc[3] = 12'h456;

  vga_scan_compositor #(.LAYER_LAT(0)) dut_0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pe0),
    .pixel_x(zx), .pixel_y(zy),
    .layer_color(z_lc), .layer_en(z_le), .bg_color(12'h00F),
    .rgb_out(z_rgb), .hsync_n(z_hs), .vsync_n(z_vs), .de(z_de),
    .frame_start(z_fs), .frame_cnt(z_fc)
  );

  // ---------------- dut_2 (default geometry, LAT 2) ----------------
  logic [9:0]       tx, ty;
  logic [3:0][11:0] t_lc;
  logic [3:0]       t_le = 4'b0000;
  logic [11:0]      t_rgb;
  logic             t_hs, t_vs, t_de, t_fs;
  logic [7:0]       t_fc;

  assign t_lc[0] = 12'hF0F;
  assign t_lc[1] = 12'h000;
  assign t_lc[2] = 12'h000;
  assign t_lc[3] = 12'h000;

  vga_scan_compositor #(.LAYER_LAT(2)) dut_2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pe2),
    .pixel_x(tx), .pixel_y(ty),
    .layer_color(t_lc), .layer_en(t_le), .bg_color(12'h00F),
    .rgb_out(t_rgb), .hsync_n(t_hs), .vsync_n(t_vs), .de(t_de),
    .frame_start(t_fs), .frame_cnt(t_fc)
  );

  // ---------------- expected-value model for dut_s ----------------
  function automatic logic [11:0] exp_s(input int h, input int v);
    if (h >= 16 || v >= 8)     return 12'h000;
    if (v == 3)                return 12'hF00;
    if (h < 4)                 return 12'h0F0;
    if (h == 5 || h == 12)     return 12'h0FF;
    if (h >= 12)               return 12'hABC;
    return 12'h00F;
  endfunction

  // ---------------- driver tasks ----------------
  // One clk on dut_s; keeps the bench raster model in step with the edge.
  task automatic s_tick(input logic pe);
    pe_s = pe;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      s_h = 0;
      s_v = 0;
    end else if (pe) begin
      if (s_h == 23) begin
        s_h = 0;
        s_v = (s_v == 13) ? 0 : s_v + 1;
      end else begin
        s_h = s_h + 1;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pe_s = 1'b1; pe0 = 1'b1; pe2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_h = 0;
    s_v = 0;
    pe_s = 1'b0; pe0 = 1'b0; pe2 = 1'b0;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [52:0] exp_v;
    exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'd0};
    rst_n = 1'b0;
    pe_s = 1'b1; pe0 = 1'b1; pe2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sx, sy, s_hs, s_vs, s_de, s_rgb, s_fs, s_fc} !== exp_v) begin
      errors++;
      $display("FAIL reset_s: got %h expected %h", {sx, sy, s_hs, s_vs, s_de, s_rgb, s_fs, s_fc}, exp_v);
    end
    checks++;
    if ({zx, zy, z_hs, z_vs, z_de, z_rgb, z_fs, z_fc} !== exp_v) begin
      errors++;
      $display("FAIL reset_0: got %h expected %h", {zx, zy, z_hs, z_vs, z_de, z_rgb, z_fs, z_fc}, exp_v);
    end
    checks++;
    if ({tx, ty, t_hs, t_vs, t_de, t_rgb, t_fs, t_fc} !== exp_v) begin
      errors++;
      $display("FAIL reset_2: got %h expected %h", {tx, ty, t_hs, t_vs, t_de, t_rgb, t_fs, t_fc}, exp_v);
    end
    s_h = 0;
    s_v = 0;
    pe_s = 1'b0; pe0 = 1'b0; pe2 = 1'b0;
    rst_n = 1'b1;
  endtask

  // Two full small frames with pix_en on every 4th clk, checked every clk.
  task automatic test_free_run();
    int oh, ov;
    logic pe;
    logic e_hs, e_vs, e_de, e_fs;
    logic [11:0] e_rgb;
    logic [7:0] e_fc;
    int hs_run, de_run, vs_run, fs_seen;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 12'h000; e_fc = 8'd0;
    hs_run = 0; de_run = 0; vs_run = 0; fs_seen = 0;
    for (int c = 0; c < 2720; c++) begin
      pe = (c % 4 == 3);
      oh = s_h;
      ov = s_v;
      s_tick(pe);
      e_fs = 1'b0;
      if (pe) begin
        e_hs  = !(oh >= 18 && oh < 22);
        e_vs  = !(ov >= 10 && ov < 12);
        e_de  = (oh < 16 && ov < 8);
        e_rgb = exp_s(oh, ov);
        if (oh == 23 && ov == 13) begin
          e_fs = 1'b1;
          e_fc = e_fc + 8'd1;
        end
      end
      checks++;
      if (sx !== 10'(s_h) || sy !== 10'(s_v)) begin
        errors++;
        $display("FAIL free_pixel clk %0d: got (%0d,%0d) expected (%0d,%0d)", c, sx, sy, s_h, s_v);
      end
      checks++;
      if (s_hs !== e_hs || s_vs !== e_vs) begin
        errors++;
        $display("FAIL free_sync clk %0d: got hs=%b vs=%b expected hs=%b vs=%b", c, s_hs, s_vs, e_hs, e_vs);
      end
      checks++;
      if (s_de !== e_de || s_rgb !== e_rgb) begin
        errors++;
        $display("FAIL free_pix clk %0d: got de=%b rgb=%h expected de=%b rgb=%h", c, s_de, s_rgb, e_de, e_rgb);
      end
      checks++;
      if (s_fs !== e_fs || s_fc !== e_fc) begin
        errors++;
        $display("FAIL free_frame clk %0d: got fs=%b cnt=%0d expected fs=%b cnt=%0d", c, s_fs, s_fc, e_fs, e_fc);
      end
      if (s_fs === 1'b1) fs_seen++;
      if (pe) begin
        if (s_hs === 1'b0) hs_run++;
        else if (hs_run != 0) begin
          checks++;
          if (hs_run != 4) begin
            errors++;
            $display("FAIL hsync_width: got %0d ticks expected 4", hs_run);
          end
          hs_run = 0;
        end
        if (s_de === 1'b1) de_run++;
        else if (de_run != 0) begin
          checks++;
          if (de_run != 16) begin
            errors++;
            $display("FAIL de_width: got %0d ticks expected 16", de_run);
          end
          de_run = 0;
        end
        if (s_vs === 1'b0) vs_run++;
        else if (vs_run != 0) begin
          checks++;
          if (vs_run != 48) begin
            errors++;
            $display("FAIL vsync_width: got %0d ticks expected 48", vs_run);
          end
          vs_run = 0;
        end
      end
    end
    checks++;
    if (fs_seen != 2 || s_fc !== 8'd2) begin
      errors++;
      $display("FAIL frame_count: got pulses=%0d cnt=%0d expected pulses=2 cnt=2", fs_seen, s_fc);
    end
  endtask

  // Reset in mid-frame at (20,10), inside both sync windows.
  task automatic test_midframe_reset();
    apply_reset();
    for (int i = 0; i < 336 + 260; i++) s_tick(1'b1);
    checks++;
    if (sx !== 10'd20 || sy !== 10'd10 || s_fc !== 8'd1 || s_hs !== 1'b0 || s_vs !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: got (%0d,%0d) cnt=%0d hs=%b vs=%b expected (20,10) cnt=1 hs=0 vs=0",
               sx, sy, s_fc, s_hs, s_vs);
    end
    rst_n = 1'b0;
    s_tick(1'b1);
    rst_n = 1'b1;
    checks++;
    if (sx !== 10'd0 || sy !== 10'd0 || s_de !== 1'b0 || s_hs !== 1'b1 || s_vs !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_timing: got (%0d,%0d) de=%b hs=%b vs=%b expected (0,0) de=0 hs=1 vs=1",
               sx, sy, s_de, s_hs, s_vs);
    end
    checks++;
    if (s_fc !== 8'd0 || s_fs !== 1'b0 || s_rgb !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_frame: got cnt=%0d fs=%b rgb=%h expected cnt=0 fs=0 rgb=000", s_fc, s_fs, s_rgb);
    end
    s_tick(1'b0);
    checks++;
    if (sx !== 10'd0 || s_de !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold: got x=%0d de=%b expected x=0 de=0", sx, s_de);
    end
    s_tick(1'b1);
    checks++;
    if (sx !== 10'd1 || sy !== 10'd0 || s_de !== 1'b1 || s_rgb !== 12'h0F0 || s_fs !== 1'b0) begin
      errors++;
      $display("FAIL mid_resume: got (%0d,%0d) de=%b rgb=%h fs=%b expected (1,0) de=1 rgb=0F0 fs=0",
               sx, sy, s_de, s_rgb, s_fs);
    end
  endtask

  // Directed priority vectors on the first pixels of line 0.
  task automatic test_priority();
    logic [3:0]  v_en  [5] = '{4'b0101, 4'b0100, 4'b0000, 4'b1010, 4'b1000};
    logic [11:0] v_rgb [5] = '{12'hF00, 12'h0F0, 12'h00F, 12'h123, 12'h456};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      z_le = v_en[i];
      pe0 = 1'b1;
      @(posedge clk);
      #1;
      pe0 = 1'b0;
      checks++;
      if (z_rgb !== v_rgb[i] || z_de !== 1'b1) begin
        errors++;
        $display("FAIL priority[%0d] en=%b: got rgb=%h de=%b expected rgb=%h de=1", i, v_en[i], z_rgb, z_de, v_rgb[i]);
      end
    end
    checks++;
    if (zx !== 10'd5 || zy !== 10'd0) begin
      errors++;
      $display("FAIL priority_pos: got (%0d,%0d) expected (5,0)", zx, zy);
    end
  endtask

  // All layers on at h=700: blanked, de low, inside hsync.
  task automatic test_blanking();
    z_le = 4'b0000;
    pe0 = 1'b1;
    repeat (695) @(posedge clk);
    #1;
    checks++;
    if (zx !== 10'd700 || zy !== 10'd0) begin
      errors++;
      $display("FAIL blank_pos: got (%0d,%0d) expected (700,0)", zx, zy);
    end
    z_le = 4'b1111;
    @(posedge clk);
    #1;
    pe0 = 1'b0;
    checks++;
    if (z_rgb !== 12'h000 || z_de !== 1'b0 || z_hs !== 1'b0 || z_vs !== 1'b1) begin
      errors++;
      $display("FAIL blanking: got rgb=%h de=%b hs=%b vs=%b expected rgb=000 de=0 hs=0 vs=1",
               z_rgb, z_de, z_hs, z_vs);
    end
    z_le = 4'b0000;
  endtask

  // LAYER_LAT=2 with a renderer delayed two ticks that lights only (100,50).
  task automatic test_latency();
    int ch, cv, c1h, c1v, c2h, c2v;
    logic v1, v2, act;
    logic [11:0] e_rgb;
    int t, t100, trgb, first_de, nhit;
    apply_reset();
    ch = 0; cv = 0; c1h = 0; c1v = 0; c2h = 0; c2v = 0;
    v1 = 1'b0; v2 = 1'b0;
    t = 0; t100 = -1; trgb = -1; first_de = -1; nhit = 0;
    for (int n = 0; n < 41000; n++) begin
      if (ch == 110 && cv == 50) break;
      t_le = (v2 && c2h == 100 && c2v == 50) ? 4'b0001 : 4'b0000;
      pe2 = 1'b1;
      @(posedge clk);
      #1;
      t++;
      act   = v2 && c2h < 640 && c2v < 480;
      e_rgb = !act ? 12'h000 : ((c2h == 100 && c2v == 50) ? 12'hF0F : 12'h00F);
      checks++;
      if (t_rgb !== e_rgb || t_de !== act) begin
        errors++;
        $display("FAIL latency_pix tick %0d: got rgb=%h de=%b expected rgb=%h de=%b", t, t_rgb, t_de, e_rgb, act);
      end
      if (tx === 10'd100 && ty === 10'd50 && t100 < 0) t100 = t;
      if (t_rgb === 12'hF0F) begin
        nhit++;
        if (trgb < 0) trgb = t;
      end
      if (t_de === 1'b1 && first_de < 0) first_de = t;
      c2h = c1h; c2v = c1v; v2 = v1;
      c1h = ch;  c1v = cv;  v1 = 1'b1;
      if (ch == 799) begin
        ch = 0;
        cv = (cv == 524) ? 0 : cv + 1;
      end else begin
        ch = ch + 1;
      end
    end
    pe2 = 1'b0;
    t_le = 4'b0000;
    checks++;
    if (first_de != 3) begin
      errors++;
      $display("FAIL first_de: got tick %0d expected tick 3", first_de);
    end
    checks++;
    if (nhit != 1 || t100 < 0 || trgb - t100 != 3) begin
      errors++;
      $display("FAIL latency_hit: got hits=%0d offset=%0d expected hits=1 offset=3", nhit, trgb - t100);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_midframe_reset();
    test_priority();
    test_blanking();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
